// File: rtl/int_rs_pkg.sv
// Shared defaults (cpu_params) and uop/entry/issue types (int_rs_types) for
// the integer reservation station.
package cpu_params;
   localparam int RS_DEPTH   = 8;
   localparam int CDB_WIDTH  = 2;
   localparam int PRF_IDX_W  = 6;
   localparam int ROB_ID_W   = 6;
   localparam int ARCH_IDX_W = 5;
   localparam int XLEN       = 32;
endpackage

package int_rs_types;
   import cpu_params::*;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_e;

   typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
   typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

   typedef struct packed {
      alu_op_e                 opcode;
      op1_sel_e                op1_sel;
      op2_sel_e                op2_sel;
      logic [XLEN-1:0]         imm;
      logic [PRF_IDX_W-1:0]    rs1_phy;
      logic                    rs1_rdy;
      logic [PRF_IDX_W-1:0]    rs2_phy;
      logic                    rs2_rdy;
      logic [PRF_IDX_W-1:0]    rd_phy;
      logic [ARCH_IDX_W-1:0]   rd_arch;
      logic [ROB_ID_W-1:0]     rob_id;
   } int_rs_dispatch_t;

   // Stored payload: readiness lives in the entry flags, not here.
   typedef struct packed {
      alu_op_e                 opcode;
      op1_sel_e                op1_sel;
      op2_sel_e                op2_sel;
      logic [XLEN-1:0]         imm;
      logic [PRF_IDX_W-1:0]    rs1_phy;
      logic [PRF_IDX_W-1:0]    rs2_phy;
      logic [PRF_IDX_W-1:0]    rd_phy;
      logic [ARCH_IDX_W-1:0]   rd_arch;
      logic [ROB_ID_W-1:0]     rob_id;
   } int_rs_payload_t;

   typedef struct packed {
      logic            valid;
      logic            src1_rdy;
      logic            src2_rdy;
      int_rs_payload_t payload;
   } int_rs_entry_t;

   typedef struct packed {
      alu_op_e                 opcode;
      op1_sel_e                op1_sel;
      op2_sel_e                op2_sel;
      logic [XLEN-1:0]         imm;
      logic [XLEN-1:0]         rs1_value;
      logic [XLEN-1:0]         rs2_value;
      logic [PRF_IDX_W-1:0]    rd_phy;
      logic [ARCH_IDX_W-1:0]   rd_arch;
      logic [ROB_ID_W-1:0]     rob_id;
   } fu_alu_reg_t;
endpackage

// File: rtl/int_rs_age_matrix.sv
// Age matrix for the integer RS: age_q[j][k]=1 means entry k is older than j.
// Selects the oldest eligible entry.
module int_rs_age_matrix #(
   parameter int RS_DEPTH = 8,
   parameter int IDX_W    = 3
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                alloc_en_i,
   input  logic [IDX_W-1:0]    alloc_idx_i,
   input  logic [RS_DEPTH-1:0] valid_i,
   input  logic                issue_en_i,
   input  logic [IDX_W-1:0]    issue_idx_i,
   input  logic [RS_DEPTH-1:0] eligible_i,
   output logic [IDX_W-1:0]    sel_idx_o
);
   logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
   logic [RS_DEPTH-1:0]               oldest;

   always_comb begin
      age_d = age_q;
      for (int j = 0; j < RS_DEPTH; j++) begin
         for (int k = 0; k < RS_DEPTH; k++) begin
            if (alloc_en_i && alloc_idx_i == IDX_W'(j)) age_d[j][k] = valid_i[k];
            if (alloc_en_i && alloc_idx_i == IDX_W'(k)) age_d[j][k] = 1'b0;
            // An entry leaving this cycle must not count as older for a newcomer.
            if (issue_en_i && (issue_idx_i == IDX_W'(j) || issue_idx_i == IDX_W'(k)))
               age_d[j][k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) age_q <= '0;
      else                age_q <= age_d;
   end

   always_comb begin
      for (int j = 0; j < RS_DEPTH; j++)
         oldest[j] = eligible_i[j] && ((age_q[j] & eligible_i) == '0);
      sel_idx_o = '0;
      for (int j = RS_DEPTH-1; j >= 0; j--)
         if (oldest[j]) sel_idx_o = IDX_W'(j);
   end
endmodule

// File: rtl/int_rs.sv
// Integer reservation station: CDB wakeup, single issue to the ALU.
// Define INT_RS_AGE_SELECT_EN for oldest-first select; default is lowest index.
module int_rs
   import int_rs_types::*;
#(
   parameter int RS_DEPTH  = cpu_params::RS_DEPTH,
   parameter int CDB_WIDTH = cpu_params::CDB_WIDTH,
   parameter int PRF_IDX_W = cpu_params::PRF_IDX_W
)(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic                                dispatch_valid,
   output logic                                dispatch_ready,
   input  int_rs_dispatch_t                    dispatch_uop,
   input  logic [CDB_WIDTH-1:0]                cdb_valid,
   input  logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cdb_rd_phy,
   output logic [PRF_IDX_W-1:0]                prf_rs1_phy,
   output logic [PRF_IDX_W-1:0]                prf_rs2_phy,
   input  logic [31:0]                         prf_rs1_value,
   input  logic [31:0]                         prf_rs2_value,
   output logic                                int_rs_valid,
   input  logic                                fu_alu_ready,
   output fu_alu_reg_t                         fu_alu_reg_out
);
   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   int_rs_entry_t       entry_q [RS_DEPTH];
   int_rs_entry_t       entry_d [RS_DEPTH];
   logic [RS_DEPTH-1:0] valid_vec, elig_vec;
   logic [IDX_W-1:0]    alloc_idx, sel_idx;
   logic                disp_fire, issue_fire;
   logic                disp_hit1, disp_hit2;
   int_rs_payload_t     sel_p;

   for (genvar i = 0; i < RS_DEPTH; i++) begin : g_vec
      assign valid_vec[i] = entry_q[i].valid;
      assign elig_vec[i]  = entry_q[i].valid && entry_q[i].src1_rdy && entry_q[i].src2_rdy;
   end

   assign dispatch_ready = ~&valid_vec;
   assign disp_fire      = dispatch_valid && dispatch_ready && !flush;
   assign int_rs_valid   = (|elig_vec) && !flush;
   assign issue_fire     = int_rs_valid && fu_alu_ready;

   always_comb begin
      alloc_idx = '0;
      for (int i = RS_DEPTH-1; i >= 0; i--)
         if (!entry_q[i].valid) alloc_idx = IDX_W'(i);
   end

`ifdef INT_RS_AGE_SELECT_EN
   int_rs_age_matrix #(
      .RS_DEPTH (RS_DEPTH),
      .IDX_W    (IDX_W)
   ) u_age (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .alloc_en_i  (disp_fire),
      .alloc_idx_i (alloc_idx),
      .valid_i     (valid_vec),
      .issue_en_i  (issue_fire),
      .issue_idx_i (sel_idx),
      .eligible_i  (elig_vec),
      .sel_idx_o   (sel_idx)
   );
`else
   always_comb begin
      sel_idx = '0;
      for (int i = RS_DEPTH-1; i >= 0; i--)
         if (elig_vec[i]) sel_idx = IDX_W'(i);
   end
`endif

   // A tag broadcast in the dispatch cycle would otherwise be missed forever.
   always_comb begin
      disp_hit1 = dispatch_uop.rs1_rdy;
      disp_hit2 = dispatch_uop.rs2_rdy;
      for (int c = 0; c < CDB_WIDTH; c++) begin
         if (cdb_valid[c] && cdb_rd_phy[c] == dispatch_uop.rs1_phy) disp_hit1 = 1'b1;
         if (cdb_valid[c] && cdb_rd_phy[c] == dispatch_uop.rs2_phy) disp_hit2 = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         entry_d[i] = entry_q[i];
         for (int c = 0; c < CDB_WIDTH; c++) begin
            if (cdb_valid[c] && cdb_rd_phy[c] == entry_q[i].payload.rs1_phy)
               entry_d[i].src1_rdy = 1'b1;
            if (cdb_valid[c] && cdb_rd_phy[c] == entry_q[i].payload.rs2_phy)
               entry_d[i].src2_rdy = 1'b1;
         end
      end
      if (issue_fire) entry_d[sel_idx].valid = 1'b0;
      if (disp_fire) begin
         entry_d[alloc_idx].valid           = 1'b1;
         entry_d[alloc_idx].src1_rdy        = disp_hit1;
         entry_d[alloc_idx].src2_rdy        = disp_hit2;
         entry_d[alloc_idx].payload.opcode  = dispatch_uop.opcode;
         entry_d[alloc_idx].payload.op1_sel = dispatch_uop.op1_sel;
         entry_d[alloc_idx].payload.op2_sel = dispatch_uop.op2_sel;
         entry_d[alloc_idx].payload.imm     = dispatch_uop.imm;
         entry_d[alloc_idx].payload.rs1_phy = dispatch_uop.rs1_phy;
         entry_d[alloc_idx].payload.rs2_phy = dispatch_uop.rs2_phy;
         entry_d[alloc_idx].payload.rd_phy  = dispatch_uop.rd_phy;
         entry_d[alloc_idx].payload.rd_arch = dispatch_uop.rd_arch;
         entry_d[alloc_idx].payload.rob_id  = dispatch_uop.rob_id;
      end
      if (flush)
         for (int i = 0; i < RS_DEPTH; i++) entry_d[i].valid = 1'b0;
   end

   // Only the valid bits are reset; payload and ready flags are qualified by valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_DEPTH; i++) entry_q[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) entry_q[i] <= entry_d[i];
      end
   end

   assign sel_p       = entry_q[sel_idx].payload;
   assign prf_rs1_phy = sel_p.rs1_phy;
   assign prf_rs2_phy = sel_p.rs2_phy;

   always_comb begin
      fu_alu_reg_out.opcode    = sel_p.opcode;
      fu_alu_reg_out.op1_sel   = sel_p.op1_sel;
      fu_alu_reg_out.op2_sel   = sel_p.op2_sel;
      fu_alu_reg_out.imm       = sel_p.imm;
      fu_alu_reg_out.rs1_value = prf_rs1_value;
      fu_alu_reg_out.rs2_value = prf_rs2_value;
      fu_alu_reg_out.rd_phy    = sel_p.rd_phy;
      fu_alu_reg_out.rd_arch   = sel_p.rd_arch;
      fu_alu_reg_out.rob_id    = sel_p.rob_id;
   end
endmodule

// File: tb/tb_int_rs.sv
// Self-checking bench for int_rs: directed scenarios then randomized traffic,
// all checked against a slot/sequence-number reference model.
module tb_int_rs;
   import cpu_params::*;
   import int_rs_types::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                                rst, flush, dispatch_valid, dispatch_ready;
   int_rs_dispatch_t                    dispatch_uop;
   logic [CDB_WIDTH-1:0]                cdb_valid;
   logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cdb_rd_phy;
   logic [PRF_IDX_W-1:0]                prf_rs1_phy, prf_rs2_phy;
   logic [31:0]                         prf_rs1_value, prf_rs2_value;
   logic                                int_rs_valid, fu_alu_ready;
   fu_alu_reg_t                         fu_alu_reg_out;
   logic [31:0]                         prf_mem [64];

   assign prf_rs1_value = prf_mem[prf_rs1_phy];
   assign prf_rs2_value = prf_mem[prf_rs2_phy];

   int_rs u_dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .dispatch_valid (dispatch_valid),
      .dispatch_ready (dispatch_ready),
      .dispatch_uop   (dispatch_uop),
      .cdb_valid      (cdb_valid),
      .cdb_rd_phy     (cdb_rd_phy),
      .prf_rs1_phy    (prf_rs1_phy),
      .prf_rs2_phy    (prf_rs2_phy),
      .prf_rs1_value  (prf_rs1_value),
      .prf_rs2_value  (prf_rs2_value),
      .int_rs_valid   (int_rs_valid),
      .fu_alu_ready   (fu_alu_ready),
      .fu_alu_reg_out (fu_alu_reg_out)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Reference model: slots with a dispatch sequence number for age order.
   bit               m_v  [RS_DEPTH];
   bit               m_r1 [RS_DEPTH];
   bit               m_r2 [RS_DEPTH];
   int               m_seq[RS_DEPTH];
   int_rs_dispatch_t m_u  [RS_DEPTH];
   int               seq_cnt = 0;

   function automatic int model_sel();
      int s = -1;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef INT_RS_AGE_SELECT_EN
            if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
            if (s < 0) s = i;
`endif
         end
      end
      return s;
   endfunction

   function automatic bit cdb_hit(input logic [PRF_IDX_W-1:0] tag);
      for (int c = 0; c < CDB_WIDTH; c++)
         if (cdb_valid[c] && cdb_rd_phy[c] == tag) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int_rs_dispatch_t mk(input int rob, input int rs1, input bit r1,
                                           input int rs2, input bit r2, input int rd);
      int_rs_dispatch_t u;
      u.opcode  = alu_op_e'($urandom_range(0, 9));
      u.op1_sel = op1_sel_e'($urandom_range(0, 2));
      u.op2_sel = op2_sel_e'($urandom_range(0, 2));
      u.imm     = $urandom;
      u.rs1_phy = PRF_IDX_W'(rs1);
      u.rs1_rdy = r1;
      u.rs2_phy = PRF_IDX_W'(rs2);
      u.rs2_rdy = r2;
      u.rd_phy  = PRF_IDX_W'(rd);
      u.rd_arch = ARCH_IDX_W'($urandom);
      u.rob_id  = ROB_ID_W'(rob);
      return u;
   endfunction

   // Inputs are set just after a negedge; compare, advance model, move to next negedge.
   task automatic tick();
      int s, f;
      bit er, ev;
      #1;
      s  = model_sel();
      er = 1'b0;
      f  = -1;
      for (int i = RS_DEPTH-1; i >= 0; i--) if (!m_v[i]) begin er = 1'b1; f = i; end
      ev = (s >= 0) && !flush;
      if (!rst) begin
         chk("disp_rdy", 32'(dispatch_ready), 32'(er));
         chk("iss_vld", 32'(int_rs_valid), 32'(ev));
         if (ev) begin
            chk("rob_id", 32'(fu_alu_reg_out.rob_id), 32'(m_u[s].rob_id));
            chk("rd_phy", 32'(fu_alu_reg_out.rd_phy), 32'(m_u[s].rd_phy));
            chk("rd_arch", 32'(fu_alu_reg_out.rd_arch), 32'(m_u[s].rd_arch));
            chk("opcode", 32'(fu_alu_reg_out.opcode), 32'(m_u[s].opcode));
            chk("op2_sel", 32'(fu_alu_reg_out.op2_sel), 32'(m_u[s].op2_sel));
            chk("imm", fu_alu_reg_out.imm, m_u[s].imm);
            chk("prf_rs1", 32'(prf_rs1_phy), 32'(m_u[s].rs1_phy));
            chk("prf_rs2", 32'(prf_rs2_phy), 32'(m_u[s].rs2_phy));
            chk("rs1_val", fu_alu_reg_out.rs1_value, prf_mem[m_u[s].rs1_phy]);
            chk("rs2_val", fu_alu_reg_out.rs2_value, prf_mem[m_u[s].rs2_phy]);
         end
      end
      if (rst || flush) begin
         for (int i = 0; i < RS_DEPTH; i++) m_v[i] = 1'b0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) if (m_v[i]) begin
            if (cdb_hit(m_u[i].rs1_phy)) m_r1[i] = 1'b1;
            if (cdb_hit(m_u[i].rs2_phy)) m_r2[i] = 1'b1;
         end
         if (ev && fu_alu_ready) m_v[s] = 1'b0;
         if (dispatch_valid && er) begin
            m_v[f]   = 1'b1;
            m_u[f]   = dispatch_uop;
            m_r1[f]  = dispatch_uop.rs1_rdy || cdb_hit(dispatch_uop.rs1_phy);
            m_r2[f]  = dispatch_uop.rs2_rdy || cdb_hit(dispatch_uop.rs2_phy);
            m_seq[f] = seq_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) prf_mem[i] = $urandom;
      rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; fu_alu_ready = 1'b0;
      cdb_valid = '0; cdb_rd_phy = '0; dispatch_uop = mk(0, 0, 1, 0, 1, 0);
      @(negedge clk);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_vld", 32'(int_rs_valid), 32'd0);
      chk("rst_rdy", 32'(dispatch_ready), 32'd1);
      tick();

      // Ready ADD issues next cycle with PRF values 5 and 3
      prf_mem[1] = 32'd5; prf_mem[2] = 32'd3;
      dispatch_uop = mk(1, 1, 1, 2, 1, 7);
      dispatch_uop.opcode = ALU_ADD;
      dispatch_valid = 1'b1;
      tick();
      dispatch_valid = 1'b0;
      #1;
      chk("t1_vld", 32'(int_rs_valid), 32'd1);
      chk("t1_rs1", fu_alu_reg_out.rs1_value, 32'd5);
      chk("t1_rs2", fu_alu_reg_out.rs2_value, 32'd3);
      chk("t1_rd", 32'(fu_alu_reg_out.rd_phy), 32'd7);
      chk("t1_op", 32'(fu_alu_reg_out.opcode), 32'(ALU_ADD));
      tick();
      fu_alu_ready = 1'b1;
      tick();
      fu_alu_ready = 1'b0;
      #1;
      chk("t1_freed", 32'(int_rs_valid), 32'd0);
      tick();

      // CDB wakeup on port 1
      dispatch_uop = mk(2, 12, 0, 3, 1, 8);
      dispatch_valid = 1'b1;
      tick();
      dispatch_valid = 1'b0;
      tick();
      #1 chk("t2_wait", 32'(int_rs_valid), 32'd0);
      cdb_valid = 2'b10; cdb_rd_phy[1] = 6'd12;
      tick();
      cdb_valid = '0;
      #1;
      chk("t2_woke", 32'(int_rs_valid), 32'd1);
      chk("t2_rob", 32'(fu_alu_reg_out.rob_id), 32'd2);
      fu_alu_ready = 1'b1;
      tick();
      fu_alu_ready = 1'b0;

      // Broadcast in the dispatch cycle
      dispatch_uop = mk(3, 4, 1, 9, 0, 10);
      dispatch_valid = 1'b1;
      cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd9;
      tick();
      dispatch_valid = 1'b0; cdb_valid = '0;
      #1;
      chk("t3_vld", 32'(int_rs_valid), 32'd1);
      chk("t3_rob", 32'(fu_alu_reg_out.rob_id), 32'd3);
      fu_alu_ready = 1'b1;
      tick();
      fu_alu_ready = 1'b0;

      // Fill, ignore 9th, free one
      for (int i = 0; i < RS_DEPTH; i++) begin
         dispatch_uop = mk(8 + i, 20 + i, 0, 5, 1, i);
         dispatch_valid = 1'b1;
         tick();
      end
      dispatch_uop = mk(31, 4, 1, 5, 1, 1);
      #1 chk("t4_full", 32'(dispatch_ready), 32'd0);
      tick();
      dispatch_valid = 1'b0;
      cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd23;
      tick();
      cdb_valid = '0;
      fu_alu_ready = 1'b1;
      #1;
      chk("t4_vld", 32'(int_rs_valid), 32'd1);
      chk("t4_rob", 32'(fu_alu_reg_out.rob_id), 32'd11);
      tick();
      fu_alu_ready = 1'b0;
      #1 chk("t4_rdy", 32'(dispatch_ready), 32'd1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // Backpressure holds selection, then one issue per cycle
      dispatch_valid = 1'b1;
      dispatch_uop = mk(40, 1, 1, 2, 1, 3);
      tick();
      dispatch_uop = mk(41, 2, 1, 1, 1, 4);
      tick();
      dispatch_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t5_hold", 32'(fu_alu_reg_out.rob_id), 32'd40);
         tick();
      end
      fu_alu_ready = 1'b1;
      #1 chk("t5_iss0", 32'(fu_alu_reg_out.rob_id), 32'd40);
      tick();
      #1;
      chk("t5_iss1", 32'(fu_alu_reg_out.rob_id), 32'd41);
      chk("t5_vld1", 32'(int_rs_valid), 32'd1);
      tick();
      fu_alu_ready = 1'b0;
      #1 chk("t5_empty", 32'(int_rs_valid), 32'd0);
      tick();

      // Flush with 5 entries and a concurrent (ready) dispatch
      for (int i = 0; i < 5; i++) begin
         dispatch_uop = mk(42 + i, 40 + i, 0, 1, 1, i);
         dispatch_valid = 1'b1;
         tick();
      end
      dispatch_uop = mk(60, 1, 1, 2, 1, 9);
      flush = 1'b1;
      #1 chk("t6_fl_vld", 32'(int_rs_valid), 32'd0);
      tick();
      flush = 1'b0; dispatch_valid = 1'b0;
      #1;
      chk("t6_vld", 32'(int_rs_valid), 32'd0);
      chk("t6_rdy", 32'(dispatch_ready), 32'd1);
      cdb_valid = 2'b11; cdb_rd_phy[0] = 6'd40; cdb_rd_phy[1] = 6'd41;
      tick();
      cdb_valid = '0;
      #1 chk("t6_gone", 32'(int_rs_valid), 32'd0);
      tick();

      // Age vs index select
      dispatch_valid = 1'b1;
      dispatch_uop = mk(50, 1, 1, 2, 1, 1);
      tick();
      dispatch_uop = mk(51, 33, 0, 2, 1, 2);
      tick();
      dispatch_valid = 1'b0;
      fu_alu_ready = 1'b1;
      #1 chk("t7_a", 32'(fu_alu_reg_out.rob_id), 32'd50);
      tick();
      fu_alu_ready = 1'b0;
      dispatch_valid = 1'b1;
      dispatch_uop = mk(52, 34, 0, 2, 1, 3);
      tick();
      dispatch_valid = 1'b0;
      cdb_valid = 2'b11; cdb_rd_phy[0] = 6'd33; cdb_rd_phy[1] = 6'd34;
      tick();
      cdb_valid = '0;
`ifdef INT_RS_AGE_SELECT_EN
      #1 chk("t7_first", 32'(fu_alu_reg_out.rob_id), 32'd51);
`else
      #1 chk("t7_first", 32'(fu_alu_reg_out.rob_id), 32'd52);
`endif
      fu_alu_ready = 1'b1;
      tick(); tick();
      fu_alu_ready = 1'b0;
      tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         dispatch_valid = ($urandom_range(0, 1) == 1);
         dispatch_uop   = mk($urandom_range(0, 63), $urandom_range(0, 15), ($urandom_range(0, 2) == 0),
                             $urandom_range(0, 15), ($urandom_range(0, 2) == 0), $urandom_range(0, 63));
         for (int c = 0; c < CDB_WIDTH; c++) begin
            cdb_valid[c]  = ($urandom_range(0, 2) == 0);
            cdb_rd_phy[c] = PRF_IDX_W'($urandom_range(0, 15));
         end
         fu_alu_ready = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 49) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
